// File: rtl/writeback_stage_buf.sv
// rtl/writeback_stage_buf.sv - buffered writeback stage with load formatting and retire counter
//
// Purpose: accepts memory-stage results over a valid/ready handshake and keeps
// them in a small skid FIFO. Load data is aligned and extended when the entry
// is enqueued, so the head of the FIFO already holds regfile-ready data. The
// head drives the regfile write port and the commit/trace port. instret counts
// every retire.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid / in_ready   upstream handshake (in_ready depends only on state)
//   in_pc, in_instr       instruction PC and raw encoding
//   in_dst, in_regwrite   destination register and write flag
//   in_memread            entry is a load
//   in_memsize            load size 0=B 1=H 2=W 3=D
//   in_memunsigned        zero-extend the load
//   in_addr_lo            byte offset of the load within the word
//   in_aluout             ALU result for non-loads
//   in_readdata           raw memory word
//   out_valid / out_ready downstream commit handshake
//   wb_en, wb_dst, wb_data      regfile write port
//   commit_pc, commit_instr     retiring instruction
//   instret                     retired-instruction counter
module writeback_stage_buf #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 64,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [31:0]               in_instr,
  input  logic [4:0]                in_dst,
  input  logic                      in_regwrite,
  input  logic                      in_memread,
  input  logic [1:0]                in_memsize,
  input  logic                      in_memunsigned,
  input  logic [$clog2(XLEN/8)-1:0] in_addr_lo,
  input  logic [XLEN-1:0]           in_aluout,
  input  logic [XLEN-1:0]           in_readdata,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic                      wb_en,
  output logic [4:0]                wb_dst,
  output logic [XLEN-1:0]           wb_data,
  output logic [XLEN-1:0]           commit_pc,
  output logic [31:0]               commit_instr,
  output logic [CNT_W-1:0]          instret
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_FW = $clog2(DEPTH + 1);

  // FIFO storage, indexed by head/tail pointers
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [31:0]     instr_q [DEPTH];
  logic [4:0]      dst_q   [DEPTH];
  logic            rw_q    [DEPTH];
  logic [XLEN-1:0] data_q  [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_FW-1:0] count_q, count_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  logic            push;
  logic            pop;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_fmt;
  logic [XLEN-1:0] enq_data;

  assign in_ready  = (count_q < CNT_FW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Load alignment and extension, done before the entry is stored
  always_comb begin
    shifted  = in_readdata >> {in_addr_lo, 3'b000};
    load_fmt = '0;
    case (in_memsize)
      2'd0: load_fmt = in_memunsigned ? XLEN'(shifted[7:0])
                                      : XLEN'($signed(shifted[7:0]));
      2'd1: load_fmt = in_memunsigned ? XLEN'(shifted[15:0])
                                      : XLEN'($signed(shifted[15:0]));
      2'd2: load_fmt = in_memunsigned ? XLEN'(shifted[31:0])
                                      : XLEN'($signed(shifted[31:0]));
      default: begin
        // A double on a 32-bit datapath degenerates to a word
        if (XLEN > 32) begin
          load_fmt = shifted;
        end else begin
          load_fmt = in_memunsigned ? XLEN'(shifted[31:0])
                                    : XLEN'($signed(shifted[31:0]));
        end
      end
    endcase
    enq_data = in_memread ? load_fmt : in_aluout;
  end

  // Pointer, occupancy and retire-counter next state
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    instret_d = instret_q;
    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d    = head_q + PTR_W'(1);
      instret_d = instret_q + CNT_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_FW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_FW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      instret_q <= '0;
      // Clearing storage makes the head-driven outputs read zero after reset
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
        dst_q[i]   <= '0;
        rw_q[i]    <= 1'b0;
        data_q[i]  <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      instret_q <= instret_d;
      if (push) begin
        pc_q[tail_q]    <= in_pc;
        instr_q[tail_q] <= in_instr;
        dst_q[tail_q]   <= in_dst;
        rw_q[tail_q]    <= in_regwrite;
        data_q[tail_q]  <= enq_data;
      end
    end
  end

  // x0 writes are suppressed but the instruction still retires
  assign wb_en        = pop && rw_q[head_q] && (dst_q[head_q] != 5'd0);
  assign wb_dst       = dst_q[head_q];
  assign wb_data      = data_q[head_q];
  assign commit_pc    = pc_q[head_q];
  assign commit_instr = instr_q[head_q];
  assign instret      = instret_q;

endmodule

// File: tb/tb_writeback_stage_buf.sv
// tb/tb_writeback_stage_buf.sv - self-checking bench for writeback_stage_buf
module tb_writeback_stage_buf;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic [4:0]  in_dst;
  logic        in_regwrite;
  logic        in_memread;
  logic [1:0]  in_memsize;
  logic        in_memunsigned;
  logic [2:0]  in_addr_lo;
  logic [63:0] in_aluout;
  logic [63:0] in_readdata;
  logic        out_ready;
  logic        out_valid;
  logic        wb_en;
  logic [4:0]  wb_dst;
  logic [63:0] wb_data;
  logic [63:0] commit_pc;
  logic [31:0] commit_instr;
  logic [63:0] instret;

  logic        in_ready4, out_valid4, wb_en4;
  logic [4:0]  wb_dst4;
  logic [63:0] wb_data4, commit_pc4;
  logic [31:0] commit_instr4;
  logic [3:0]  instret4;

  always #5 clk = ~clk;

  writeback_stage_buf #(.XLEN(64), .CNT_W(64), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_dst(in_dst), .in_regwrite(in_regwrite),
    .in_memread(in_memread), .in_memsize(in_memsize), .in_memunsigned(in_memunsigned),
    .in_addr_lo(in_addr_lo), .in_aluout(in_aluout), .in_readdata(in_readdata),
    .out_ready(out_ready), .out_valid(out_valid), .wb_en(wb_en), .wb_dst(wb_dst),
    .wb_data(wb_data), .commit_pc(commit_pc), .commit_instr(commit_instr),
    .instret(instret)
  );

  writeback_stage_buf #(.XLEN(64), .CNT_W(4), .DEPTH(DEPTH)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .in_pc(in_pc), .in_instr(in_instr), .in_dst(in_dst), .in_regwrite(in_regwrite),
    .in_memread(in_memread), .in_memsize(in_memsize), .in_memunsigned(in_memunsigned),
    .in_addr_lo(in_addr_lo), .in_aluout(in_aluout), .in_readdata(in_readdata),
    .out_ready(out_ready), .out_valid(out_valid4), .wb_en(wb_en4), .wb_dst(wb_dst4),
    .wb_data(wb_data4), .commit_pc(commit_pc4), .commit_instr(commit_instr4),
    .instret(instret4)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  dst;
    logic        rw;
    logic [63:0] data;
  } ent_t;

  typedef struct {
    logic        mr;
    logic [1:0]  sz;
    logic        uns;
    logic [2:0]  lo;
    logic [63:0] rd;
    logic [63:0] alu;
    logic [63:0] exp;
  } vec_t;

  ent_t        mq[$];
  logic [63:0] m_instret;
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        tbl[9];
  logic [63:0] base;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected regfile value from the load rules, using byte counts and masks
  function automatic logic [63:0] ref_data(input logic mr, input logic [1:0] sz,
                                           input logic uns, input logic [2:0] lo,
                                           input logic [63:0] alu, input logic [63:0] rd);
    int nb;
    logic [63:0] v, mask;
    if (!mr) return alu;
    nb = 1 << sz;
    v = rd >> (8 * lo);
    mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    v = v & mask;
    if (!uns && nb < 8 && v[8 * nb - 1]) v = v | ~mask;
    return v;
  endfunction

  // One clock: check outputs against the model mid-cycle, then advance the model
  task automatic cycle();
    bit push, pop;
    ent_t e;
    @(negedge clk);
    chk("in_ready", in_ready, mq.size() < DEPTH);
    chk("out_valid", out_valid, mq.size() > 0);
    chk("instret", instret, m_instret);
    chk("instret4", instret4, m_instret & 64'hF);
    if (mq.size() > 0) begin
      chk("wb_dst", wb_dst, mq[0].dst);
      chk("wb_data", wb_data, mq[0].data);
      chk("commit_pc", commit_pc, mq[0].pc);
      chk("commit_instr", commit_instr, mq[0].instr);
      chk("wb_en", wb_en, out_ready && mq[0].rw && mq[0].dst != 0);
    end else begin
      chk("wb_en_empty", wb_en, 0);
    end
    push = in_valid && (mq.size() < DEPTH);
    pop  = (mq.size() > 0) && out_ready;
    e.pc = in_pc; e.instr = in_instr; e.dst = in_dst; e.rw = in_regwrite;
    e.data = ref_data(in_memread, in_memsize, in_memunsigned, in_addr_lo, in_aluout, in_readdata);
    @(posedge clk);
    #1;
    if (pop) begin
      void'(mq.pop_front());
      m_instret = m_instret + 64'd1;
    end
    if (push) mq.push_back(e);
  endtask

  task automatic set_alu(input logic [63:0] pc, input logic [4:0] dst, input logic rw,
                         input logic [63:0] alu);
    in_valid = 1'b1; in_pc = pc; in_instr = pc[31:0] ^ 32'h13; in_dst = dst;
    in_regwrite = rw; in_memread = 1'b0; in_memsize = 2'd0; in_memunsigned = 1'b0;
    in_addr_lo = 3'd0; in_aluout = alu; in_readdata = 64'd0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 0; in_pc = 0; in_instr = 0; in_dst = 0; in_regwrite = 0;
    in_memread = 0; in_memsize = 0; in_memunsigned = 0; in_addr_lo = 0;
    in_aluout = 0; in_readdata = 0; out_ready = 0;
    m_instret = 0;

    tbl[0] = '{1'b0, 2'd0, 1'b0, 3'd0, 64'h0,                   64'h1234, 64'h1234};
    tbl[1] = '{1'b1, 2'd0, 1'b0, 3'd7, 64'h8877665544332211, 64'h0, 64'hFFFFFFFFFFFFFF88};
    tbl[2] = '{1'b1, 2'd0, 1'b1, 3'd7, 64'h8877665544332211, 64'h0, 64'h88};
    tbl[3] = '{1'b1, 2'd1, 1'b0, 3'd2, 64'h8877665544332211, 64'h0, 64'h4433};
    tbl[4] = '{1'b1, 2'd2, 1'b0, 3'd4, 64'h8877665544332211, 64'h0, 64'hFFFFFFFF88776655};
    tbl[5] = '{1'b1, 2'd3, 1'b0, 3'd0, 64'h8877665544332211, 64'h0, 64'h8877665544332211};
    tbl[6] = '{1'b1, 2'd1, 1'b1, 3'd6, 64'h8877665544332211, 64'h0, 64'h8877};
    tbl[7] = '{1'b1, 2'd1, 1'b0, 3'd6, 64'h8877665544332211, 64'h0, 64'hFFFFFFFFFFFF8877};
    tbl[8] = '{1'b1, 2'd2, 1'b1, 3'd4, 64'h8877665544332211, 64'h0, 64'h88776655};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_instret", instret, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_dst", wb_dst, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_commit_pc", commit_pc, 0);
    chk("rst_commit_instr", commit_instr, 0);
    cycle();

    // Table vectors: ALU result and load formatting
    for (int i = 0; i < 9; i++) begin
      set_alu(64'h80000000 + 64'(i * 4), 5'd5, 1'b1, tbl[i].alu);
      in_memread = tbl[i].mr; in_memsize = tbl[i].sz; in_memunsigned = tbl[i].uns;
      in_addr_lo = tbl[i].lo; in_readdata = tbl[i].rd;
      out_ready = 1'b0;
      base = m_instret;
      cycle();
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("tbl_out_valid", out_valid, 1);
      chk("tbl_wb_data", wb_data, tbl[i].exp);
      chk("tbl_wb_en", wb_en, 1);
      chk("tbl_wb_dst", wb_dst, 5);
      chk("tbl_commit_pc", commit_pc, 64'h80000000 + 64'(i * 4));
      cycle();
      chk("tbl_instret", instret, base + 64'd1);
    end

    // Backpressure: two accepted, third held until space frees
    out_ready = 1'b0;
    base = m_instret;
    for (int k = 0; k < 3; k++) begin
      set_alu(64'h1000 + 64'(k), 5'd10 + 5'(k), 1'b1, 64'hA0 + 64'(k));
      if (k == 2) chk("bp_full_in_ready", in_ready, 0);
      cycle();
    end
    out_ready = 1'b1;
    chk("bp_head_pc", commit_pc, 64'h1000);
    cycle();
    chk("bp_second_pc", commit_pc, 64'h1001);
    cycle();
    in_valid = 1'b0;
    #1;
    chk("bp_third_pc", commit_pc, 64'h1002);
    cycle();
    cycle();
    chk("bp_instret", instret, base + 64'd3);
    chk("bp_empty", out_valid, 0);

    // Asynchronous reset with two entries queued
    out_ready = 1'b0;
    set_alu(64'h2000, 5'd3, 1'b1, 64'h55);
    cycle();
    set_alu(64'h2004, 5'd4, 1'b1, 64'h66);
    cycle();
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_in_ready", in_ready, 1);
    chk("async_instret", instret, 0);
    chk("async_commit_pc", commit_pc, 0);
    chk("async_wb_data", wb_data, 0);
    mq.delete();
    m_instret = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Continuous stream: push and pop together, one x0 write, 17 retires
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      set_alu(64'h3000 + 64'(k * 4), (k == 5) ? 5'd0 : 5'(k + 1), 1'b1, {$urandom, $urandom});
      cycle();
      if (k > 0) chk("stream_in_ready", in_ready, 1);
      if (k == 5) begin
        chk("x0_wb_en", wb_en, 0);
        chk("x0_out_valid", out_valid, 1);
        chk("x0_wb_dst", wb_dst, 0);
      end
    end
    in_valid = 1'b0;
    cycle();
    chk("wrap_instret4", instret4, 1);
    chk("wrap_instret", instret, 17);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      in_valid       = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 2) != 0);
      in_pc          = {$urandom, $urandom};
      in_instr       = $urandom;
      in_dst         = 5'($urandom_range(0, 31));
      in_regwrite    = 1'($urandom);
      in_memread     = 1'($urandom);
      in_memsize     = 2'($urandom);
      in_memunsigned = 1'($urandom);
      in_addr_lo     = 3'($urandom);
      in_aluout      = {$urandom, $urandom};
      in_readdata    = {$urandom, $urandom};
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
